fht_seq_ctrl: RTL
=================

Name: fht_seq_ctrl

Overview:
- Sequencing controller for the four-stage 16-point Fast Hadamard Transform datapath.
- Accepts frames over a valid/ready handshake and generates the per-stage load strobes FhtStarOne..FhtStarFour.
- Tracks occupancy of each stage so up to four frames are in flight at once.
- Presents a valid/ready handshake on the Out0..Out15 side and stalls the pipeline under output backpressure.

Parameters:
- STAGE_LAT, 1, cycles from a stage's load strobe until its output registers are valid for the next stage (1..15).
- CNT_W, 16, width of the completed-frame counter.

Ports:
- Clk  input  1  system clock, all state on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Clear  input  1  synchronous flush; drops all in-flight frames.
- InValid  input  1  I0..I15 hold a new frame this cycle.
- InReady  output  1  controller accepts the frame this cycle.
- FhtStarOne  output  1  stage-1 load strobe (combinational).
- FhtStarTwo  output  1  stage-2 load strobe (combinational).
- FhtStarThree  output  1  stage-3 load strobe (combinational).
- FhtStarFour  output  1  stage-4 load strobe (combinational).
- OutValid  output  1  Out0..Out15 hold a finished frame.
- OutReady  input  1  downstream consumes the finished frame.
- Busy  output  1  any stage occupied.
- FrameCnt  output  CNT_W  frames consumed on the output since reset/Clear.

Behaviour:
- Per-stage state, k = 1..4:
  - occupancy flag V[k];
  - down-counter C[k], 4 bits.
- Stage k is "done" when V[k]=1 and C[k]=0.
- Fire conditions (combinational), evaluated from stage 4 back to stage 1:
  - Consume = OutValid & OutReady.
  - Free4 = !V[4] | Consume. FhtStarFour = done3 & Free4.
  - Free3 = !V[3] | FhtStarFour. FhtStarThree = done2 & Free3.
  - Free2 = !V[2] | FhtStarThree. FhtStarTwo = done1 & Free2.
  - InReady = !V[1] | FhtStarTwo. FhtStarOne = InValid & InReady.
- On fire of stage k: V[k]<=1 and C[k]<=STAGE_LAT-1.
- Otherwise, if stage k drains (next strobe fires, or Consume for k=4) then V[k]<=0; else C[k] decrements while nonzero.
- Fire and drain in the same cycle: fire wins, so V[k] stays 1 and C[k] reloads.
- OutValid = V[4] & (C[4]==0).
- Busy = |V.
- FrameCnt increments on Consume and wraps at 2^CNT_W-1 -> 0.
- Latency with STAGE_LAT=L: frame accepted at cycle t produces:
  - FhtStarTwo at t+L;
  - FhtStarThree at t+2L;
  - FhtStarFour at t+3L;
  - OutValid from t+4L.
- Throughput: one frame per L cycles when OutReady is held high.
- Backpressure:
  - While OutValid=1 and OutReady=0, stage 4 holds and no FhtStarFour fires.
  - Upstream stages fill, then hold.
  - InReady drops once stage 1 is full and cannot drain.
  - No frame is ever overwritten or dropped.
- InValid while InReady=0: no strobe; the source must hold the frame.
- Clear:
  - Synchronous; all V<=0, C<=0, FrameCnt<=0.
  - All strobes and InReady are forced to 0 during the Clear cycle.
  - Clear has priority over fire and consume.
- Reset (asserted low, any time including mid-frame):
  - Immediately V=0, C=0, FrameCnt=0.
  - Resulting outputs: OutValid=0, Busy=0, all strobes 0, InReady=1 once Reset is released and Clear=0.
  - In-flight frames are discarded.
- Strobes are single-cycle per transfer. They may assert on consecutive cycles when L=1.
- Out0..Out15 are valid only while OutValid=1.

Test Plan:
- Single frame, L=1, OutReady=1: InValid pulse at cycle 0 -> Star1@0, Star2@1, Star3@2, Star4@3, OutValid@4 for one cycle; FrameCnt=1; Busy low from cycle 5.
- Streaming, L=1: InValid=1 for 8 cycles with OutReady=1 -> InReady stays 1; each strobe high 8 consecutive cycles; OutValid high cycles 4..11; FrameCnt=8.
- Backpressure: OutReady=0 while streaming 6 frames -> InReady drops after the 4th accept and stalls until OutReady is set; the fifth frame is then accepted. FrameCnt=6 after draining; every output equals the FHT of its input in order (checked against a reference model).
- L=3, two back-to-back frames -> second frame accepted at cycle 3; Star2 at cycles 3 and 6; OutValid at cycles 12 and 15.
- Clear mid-flight with 3 frames loaded -> next cycle V=0, OutValid=0, FrameCnt=0; no strobe fires in the Clear cycle.
- Reset asserted low for 2 cycles mid-stream -> outputs go to reset values asynchronously; after release, a fresh frame follows single-frame timing.

Source files
------------

// File: rtl/fht_seq_ctrl.sv
// Sequencing controller for the four-stage 16-point FHT datapath.
// Each stage holds one frame. A stage is ready to hand its frame on once its
// latency counter has run down to zero. The load strobes are resolved from the
// output side back to the input side, so a frame can move into a stage in the
// same cycle that the stage's current frame moves out.
module fht_seq_ctrl #(
  parameter int STAGE_LAT = 1,
  parameter int CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Clear,
  input  logic             InValid,
  output logic             InReady,
  output logic             FhtStarOne,
  output logic             FhtStarTwo,
  output logic             FhtStarThree,
  output logic             FhtStarFour,
  output logic             OutValid,
  input  logic             OutReady,
  output logic             Busy,
  output logic [CNT_W-1:0] FrameCnt
);

  localparam logic [3:0] RELOAD = 4'(STAGE_LAT - 1);

  logic [3:0] v;
  logic [3:0] cnt [4];
  logic [3:0] done;
  logic [3:0] fire;
  logic [3:0] drain;
  logic       consume;

  // A stage is done when it is occupied and its latency has elapsed
  always_comb begin
    done = '0;
    for (int k = 0; k < 4; k++) begin
      done[k] = v[k] && (cnt[k] == 4'd0);
    end
  end

  // Clear blocks every transfer in its cycle, including the output consume
  assign OutValid     = done[3];
  assign consume      = done[3] & OutReady & ~Clear;
  assign FhtStarFour  = ~Clear & done[2] & (~v[3] | consume);
  assign FhtStarThree = ~Clear & done[1] & (~v[2] | FhtStarFour);
  assign FhtStarTwo   = ~Clear & done[0] & (~v[1] | FhtStarThree);
  assign InReady      = ~Clear & (~v[0] | FhtStarTwo);
  assign FhtStarOne   = InValid & InReady;

  assign fire  = {FhtStarFour, FhtStarThree, FhtStarTwo, FhtStarOne};
  assign drain = {consume, FhtStarFour, FhtStarThree, FhtStarTwo};
  assign Busy  = |v;

  // Occupancy flags and latency down-counters; a load wins over a drain
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      v <= '0;
      for (int k = 0; k < 4; k++) cnt[k] <= 4'd0;
    end else if (Clear) begin
      v <= '0;
      for (int k = 0; k < 4; k++) cnt[k] <= 4'd0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (fire[k]) begin
          v[k]   <= 1'b1;
          cnt[k] <= RELOAD;
        end else if (drain[k]) begin
          v[k]   <= 1'b0;
        end else if (cnt[k] != 4'd0) begin
          cnt[k] <= cnt[k] - 4'd1;
        end
      end
    end
  end

  // Count frames taken by the downstream consumer; wraps naturally
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      FrameCnt <= '0;
    end else if (Clear) begin
      FrameCnt <= '0;
    end else if (consume) begin
      FrameCnt <= FrameCnt + 1'b1;
    end
  end

endmodule
